// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : seq_pkg
//  Description : Shared opcodes, IR field positions, FSM state and opcode
//                class types for the instruction sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

  // Opcode values carried in IR[15:12]; 1..A are ALU operations
  localparam logic [3:0] c_OP_NOP   = 4'h0;
  localparam logic [3:0] c_OP_MOVIL = 4'hB;
  localparam logic [3:0] c_OP_MOVIH = 4'hC;
  localparam logic [3:0] c_OP_LOAD  = 4'hD;
  localparam logic [3:0] c_OP_STORE = 4'hE;
  localparam logic [3:0] c_OP_HALT  = 4'hF;

  // IR field bit positions
  localparam int c_OP_MSB   = 15;
  localparam int c_OP_LSB   = 12;
  localparam int c_DST_MSB  = 11;
  localparam int c_DST_LSB  = 9;
  localparam int c_SRC1_MSB = 8;
  localparam int c_SRC1_LSB = 6;
  localparam int c_SRC2_MSB = 5;
  localparam int c_SRC2_LSB = 3;
  localparam int c_IMM_MSB  = 7;
  localparam int c_IMM_LSB  = 0;

  // Sequencer states; STEP_WAIT only exists in single-step builds
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC      = 3'd3,
    ST_MEM       = 3'd4,
    ST_HALT      = 3'd5,
    ST_ERROR     = 3'd6
`ifdef DEC_SINGLE_STEP_EN
    ,ST_STEP_WAIT = 3'd7
`endif
  } seq_state_e;

  // Coarse instruction class used to pick the post-decode path
  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_ALU   = 3'd1,
    CLS_MOVIL = 3'd2,
    CLS_MOVIH = 3'd3,
    CLS_LOAD  = 3'd4,
    CLS_STORE = 3'd5,
    CLS_HALT  = 3'd6
  } op_class_e;

  // Map a 4-bit opcode onto its class
  function automatic op_class_e classify(input logic [3:0] op);
    op_class_e cls;
    case (op)
      c_OP_NOP:   cls = CLS_NOP;
      c_OP_MOVIL: cls = CLS_MOVIL;
      c_OP_MOVIH: cls = CLS_MOVIH;
      c_OP_LOAD:  cls = CLS_LOAD;
      c_OP_STORE: cls = CLS_STORE;
      c_OP_HALT:  cls = CLS_HALT;
      default:    cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_field_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_field_decode
//  Description : Purely combinational split of the instruction register into
//                regfile field outputs plus an opcode class.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_field_decode
  import seq_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [2:0]  o_src1,
  output logic [2:0]  o_src2,
  output logic [2:0]  o_dest,
  output logic [7:0]  o_imm,
  output logic [3:0]  o_op,
  output op_class_e   o_class
);

  // Fixed-position field extraction and opcode classification
  always_comb begin
    o_op    = i_ir[c_OP_MSB:c_OP_LSB];
    o_dest  = i_ir[c_DST_MSB:c_DST_LSB];
    o_src1  = i_ir[c_SRC1_MSB:c_SRC1_LSB];
    o_src2  = i_ir[c_SRC2_MSB:c_SRC2_LSB];
    o_imm   = i_ir[c_IMM_MSB:c_IMM_LSB];
    o_class = classify(i_ir[c_OP_MSB:c_OP_LSB]);
  end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Fetch/decode/commit controller in front of the regfile.
//                Fetches 16-bit instructions into the IR, sequences the
//                data-memory handshake and issues single-cycle commit strobes.
//                Optional macro DEC_SINGLE_STEP_EN adds step_pi and a
//                STEP_WAIT state after every retire.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned           PC_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
  parameter int unsigned           MEM_TIMEOUT = 15
) (
  input  logic                clk_pi,
  input  logic                reset_n_pi,
  input  logic                start_pi,
`ifdef DEC_SINGLE_STEP_EN
  input  logic                step_pi,
`endif
  output logic                imem_req_po,
  output logic [PC_WIDTH-1:0] imem_addr_po,
  input  logic                imem_ack_pi,
  input  logic [15:0]         imem_data_pi,
  output logic                dmem_req_po,
  output logic                dmem_we_po,
  input  logic                dmem_ack_pi,
  output logic                clk_en_po,
  output logic [2:0]          source_reg1_po,
  output logic [2:0]          source_reg2_po,
  output logic [2:0]          destination_reg_po,
  output logic                wr_destination_reg_po,
  output logic                movi_lower_po,
  output logic                movi_higher_po,
  output logic [7:0]          immediate_po,
  output logic [3:0]          alu_op_po,
  output logic                sel_mem_po,
  output logic                halted_po,
  output logic                error_po
);

  localparam int unsigned         c_WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);
  localparam logic [PC_WIDTH-1:0] c_PC_ONE   = PC_WIDTH'(1);

  // Where a retiring instruction goes next, and whether fetch starts at once
`ifdef DEC_SINGLE_STEP_EN
  localparam seq_state_e c_RETIRE_STATE = ST_STEP_WAIT;
  localparam logic       c_RETIRE_REQ   = 1'b0;
`else
  localparam seq_state_e c_RETIRE_STATE = ST_FETCH;
  localparam logic       c_RETIRE_REQ   = 1'b1;
`endif

  seq_state_e          r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0]         r_ir;
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_imem_req;
  logic                r_dmem_req;
  logic                r_dmem_we;
  logic                r_clk_en;
  logic                r_wr_dest;
  logic                r_movi_lo;
  logic                r_movi_hi;
  logic                r_halted;
  logic                r_error;

  op_class_e           w_class;
  logic                w_wait_expired;
  logic                w_load_ack;

  instr_field_decode u_field_decode (
    .i_ir    (r_ir),
    .o_src1  (source_reg1_po),
    .o_src2  (source_reg2_po),
    .o_dest  (destination_reg_po),
    .o_imm   (immediate_po),
    .o_op    (alu_op_po),
    .o_class (w_class)
  );

  // Handshake expiry and the LOAD commit, which lands in the dmem ack cycle itself
  always_comb begin
    w_wait_expired = (r_wait == c_WAIT_MAX);
    w_load_ack     = (r_state == ST_MEM) && dmem_ack_pi && !r_dmem_we;
  end

  // Sequencer FSM with registered requests, EXEC strobes and sticky flags
  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_wait     <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_clk_en   <= 1'b0;
      r_wr_dest  <= 1'b0;
      r_movi_lo  <= 1'b0;
      r_movi_hi  <= 1'b0;
      r_halted   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_clk_en  <= 1'b0;
      r_wr_dest <= 1'b0;
      r_movi_lo <= 1'b0;
      r_movi_hi <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_pi) begin
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
            r_wait     <= '0;
          end
        end
        ST_FETCH: begin
          if (imem_ack_pi) begin
            r_ir       <= imem_data_pi;
            r_imem_req <= 1'b0;
            r_state    <= ST_DECODE;
            r_wait     <= '0;
          end else if (w_wait_expired) begin
            r_imem_req <= 1'b0;
            r_error    <= 1'b1;
            r_state    <= ST_ERROR;
            r_wait     <= '0;
          end else begin
            r_wait <= r_wait + c_WAIT_ONE;
          end
        end
        ST_DECODE: begin
          r_wait <= '0;
          case (w_class)
            CLS_HALT: begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end
            CLS_LOAD, CLS_STORE: begin
              r_state    <= ST_MEM;
              r_dmem_req <= 1'b1;
              r_dmem_we  <= (w_class == CLS_STORE);
            end
            default: begin
              r_state   <= ST_EXEC;
              r_clk_en  <= (w_class != CLS_NOP);
              r_wr_dest <= (w_class == CLS_ALU);
              r_movi_lo <= (w_class == CLS_MOVIL);
              r_movi_hi <= (w_class == CLS_MOVIH);
            end
          endcase
        end
        ST_EXEC: begin
          r_pc       <= r_pc + c_PC_ONE;
          r_state    <= c_RETIRE_STATE;
          r_imem_req <= c_RETIRE_REQ;
          r_wait     <= '0;
        end
        ST_MEM: begin
          if (dmem_ack_pi) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_pc       <= r_pc + c_PC_ONE;
            r_state    <= c_RETIRE_STATE;
            r_imem_req <= c_RETIRE_REQ;
            r_wait     <= '0;
          end else if (w_wait_expired) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_error    <= 1'b1;
            r_state    <= ST_ERROR;
            r_wait     <= '0;
          end else begin
            r_wait <= r_wait + c_WAIT_ONE;
          end
        end
`ifdef DEC_SINGLE_STEP_EN
        ST_STEP_WAIT: begin
          if (step_pi) begin
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
            r_wait     <= '0;
          end
        end
`endif
        ST_HALT, ST_ERROR: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req_po           = r_imem_req;
  assign imem_addr_po          = r_pc;
  assign dmem_req_po           = r_dmem_req;
  assign dmem_we_po            = r_dmem_we;
  assign clk_en_po             = r_clk_en | w_load_ack;
  assign wr_destination_reg_po = r_wr_dest | w_load_ack;
  assign movi_lower_po         = r_movi_lo;
  assign movi_higher_po        = r_movi_hi;
  assign sel_mem_po            = w_load_ack;
  assign halted_po             = r_halted;
  assign error_po              = r_error;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Directed self-checking bench; commits are matched against a
//                queue of expected commit records.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  typedef struct packed {
    logic       ce;
    logic       wr;
    logic       ml;
    logic       mh;
    logic       sel;
    logic [2:0] dst;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [7:0] imm;
    logic [3:0] op;
  } commit_t;

  logic clk;
  int   n_err;
  int   n_checks;
  commit_t exp_q[$];

  // main instance (RESET_PC = 0)
  logic       rst_n, start, imem_ack, dmem_ack;
  logic [15:0] imem_data;
  logic       imem_req, dmem_req, dmem_we, clk_en, wr_dest, movi_lo, movi_hi, sel_mem, halted, error;
  logic [7:0] imem_addr, imm;
  logic [2:0] src1, src2, dest;
  logic [3:0] alu_op;

  // wrap instance (RESET_PC = 8'hFF)
  logic       rst_n_w, start_w, imem_ack_w, dmem_ack_w;
  logic [15:0] imem_data_w;
  logic       imem_req_w, dmem_req_w, dmem_we_w, clk_en_w, wr_dest_w, movi_lo_w, movi_hi_w, sel_mem_w, halted_w, error_w;
  logic [7:0] imem_addr_w, imm_w;
  logic [2:0] src1_w, src2_w, dest_w;
  logic [3:0] alu_op_w;

`ifdef DEC_SINGLE_STEP_EN
  logic step, step_w;
`endif

  instr_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00), .MEM_TIMEOUT(15)) dut (
    .clk_pi(clk), .reset_n_pi(rst_n), .start_pi(start),
`ifdef DEC_SINGLE_STEP_EN
    .step_pi(step),
`endif
    .imem_req_po(imem_req), .imem_addr_po(imem_addr), .imem_ack_pi(imem_ack),
    .imem_data_pi(imem_data), .dmem_req_po(dmem_req), .dmem_we_po(dmem_we),
    .dmem_ack_pi(dmem_ack), .clk_en_po(clk_en), .source_reg1_po(src1),
    .source_reg2_po(src2), .destination_reg_po(dest), .wr_destination_reg_po(wr_dest),
    .movi_lower_po(movi_lo), .movi_higher_po(movi_hi), .immediate_po(imm),
    .alu_op_po(alu_op), .sel_mem_po(sel_mem), .halted_po(halted), .error_po(error)
  );

  instr_sequencer #(.PC_WIDTH(8), .RESET_PC(8'hFF), .MEM_TIMEOUT(15)) dut_w (
    .clk_pi(clk), .reset_n_pi(rst_n_w), .start_pi(start_w),
`ifdef DEC_SINGLE_STEP_EN
    .step_pi(step_w),
`endif
    .imem_req_po(imem_req_w), .imem_addr_po(imem_addr_w), .imem_ack_pi(imem_ack_w),
    .imem_data_pi(imem_data_w), .dmem_req_po(dmem_req_w), .dmem_we_po(dmem_we_w),
    .dmem_ack_pi(dmem_ack_w), .clk_en_po(clk_en_w), .source_reg1_po(src1_w),
    .source_reg2_po(src2_w), .destination_reg_po(dest_w), .wr_destination_reg_po(wr_dest_w),
    .movi_lower_po(movi_lo_w), .movi_higher_po(movi_hi_w), .immediate_po(imm_w),
    .alu_op_po(alu_op_w), .sel_mem_po(sel_mem_w), .halted_po(halted_w), .error_po(error_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected commit for an instruction word, fields sliced from the word itself
  function automatic commit_t mk(input logic [15:0] ir, input logic ce, input logic wr,
                                 input logic ml, input logic mh, input logic sel);
    commit_t c;
    c.ce = ce; c.wr = wr; c.ml = ml; c.mh = mh; c.sel = sel;
    c.op = ir[15:12]; c.dst = ir[11:9]; c.s1 = ir[8:6]; c.s2 = ir[5:3]; c.imm = ir[7:0];
    return c;
  endfunction

  // Scoreboard: every cycle with a strobe active must match the next expected commit
  always @(negedge clk) begin : mon
    commit_t obs;
    commit_t e;
    #2;
    if (clk_en | wr_dest | movi_lo | movi_hi | sel_mem) begin
      obs = '{ce: clk_en, wr: wr_dest, ml: movi_lo, mh: movi_hi, sel: sel_mem,
              dst: dest, s1: src1, s2: src2, imm: imm, op: alu_op};
      if (exp_q.size() == 0) begin
        chk("commit_unexpected", 32'(obs), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("commit", 32'(obs), 32'(e));
      end
    end
  end

  // Wait (bounded) for a fetch request, then ack it with the given word
  task automatic fetch(input logic [15:0] instr);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req_seen", 32'(imem_req), 1);
    imem_ack  = 1'b1;
    imem_data = instr;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = '0;
  endtask

  // Gap between retire and the next fetch (only present in single-step builds)
  task automatic retire_gap();
`ifdef DEC_SINGLE_STEP_EN
    chk("step_hold_req0", 32'(imem_req), 0);
    @(negedge clk);
    chk("step_hold_req1", 32'(imem_req), 0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_hi;
    n_err = 0; n_checks = 0;
    rst_n = 0; start = 0; imem_ack = 0; imem_data = '0; dmem_ack = 0;
    rst_n_w = 0; start_w = 0; imem_ack_w = 0; imem_data_w = '0; dmem_ack_w = 0;
`ifdef DEC_SINGLE_STEP_EN
    step = 0; step_w = 0;
`endif
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h00);
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_strobes", 32'({clk_en, wr_dest, movi_lo, movi_hi, sel_mem}), 0);
    chk("rst_flags", 32'({halted, error}), 0);
    chk("rst_fields", 32'({alu_op, dest, src1, src2, imm}), 0);
    chk("rst_w_imem_addr", 32'(imem_addr_w), 32'hFF);
    rst_n = 1; rst_n_w = 1;
    @(negedge clk);

    // 1: ADD 0x1298
    start = 1;
    @(negedge clk);
    start = 0;
    chk("t1_imem_req", 32'(imem_req), 1);
    chk("t1_addr0", 32'(imem_addr), 32'h00);
    exp_q.push_back(mk(16'h1298, 1, 1, 0, 0, 0));
    fetch(16'h1298);
    chk("t1_decode_fields", 32'({alu_op, dest, src1, src2}), 32'({4'h1, 3'd1, 3'd2, 3'd3}));
    chk("t1_decode_no_commit", 32'(clk_en), 0);
    @(negedge clk);
    chk("t1_exec_clk_en", 32'({clk_en, wr_dest}), 32'h3);
    @(negedge clk);
    chk("t1_post_clk_en", 32'(clk_en), 0);
    retire_gap();
    chk("t1_addr1", 32'(imem_addr), 32'h01);
    chk("t1_refetch_req", 32'(imem_req), 1);

    // 2: MOVIL 0xBAA5
    exp_q.push_back(mk(16'hBAA5, 1, 0, 1, 0, 0));
    fetch(16'hBAA5);
    chk("t2_imm", 32'(imm), 32'hA5);
    @(negedge clk);
    chk("t2_movil", 32'({movi_lo, movi_hi, wr_dest}), 32'h4);
    @(negedge clk);
    retire_gap();
    chk("t2_addr2", 32'(imem_addr), 32'h02);

    // 3: LOAD 0xD280 with dmem ack arriving after three waiting cycles
    fetch(16'hD280);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("t3_wait_req_we_ce", 32'({dmem_req, dmem_we, clk_en, sel_mem}), 32'h8);
      @(negedge clk);
    end
    chk("t3_req_held", 32'(dmem_req), 1);
    exp_q.push_back(mk(16'hD280, 1, 1, 0, 0, 1));
    dmem_ack = 1;
    #1;
    chk("t3_ack_commit", 32'({clk_en, wr_dest, sel_mem}), 32'h7);
    @(negedge clk);
    dmem_ack = 0;
    chk("t3_post_ack", 32'({dmem_req, clk_en, sel_mem}), 0);
    retire_gap();
    chk("t3_addr3", 32'(imem_addr), 32'h03);

    // STORE 0xE280: request with we=1, no commit in the ack cycle
    fetch(16'hE280);
    @(negedge clk);
    chk("st_req_we", 32'({dmem_req, dmem_we}), 32'h3);
    dmem_ack = 1;
    #1;
    chk("st_no_commit", 32'({clk_en, wr_dest, sel_mem}), 0);
    @(negedge clk);
    dmem_ack = 0;
    retire_gap();
    chk("st_addr4", 32'(imem_addr), 32'h04);

    // 4: fetch timeout -> ERROR after 15 request cycles, start ignored
    n_hi = 0;
    for (int i = 0; i < 15; i++) begin
      if (imem_req && !error) n_hi++;
      @(negedge clk);
    end
    chk("t4_req_cycles", 32'(n_hi), 15);
    chk("t4_error", 32'({error, imem_req}), 32'h2);
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("t4_error_absorbing", 32'({error, imem_req, halted}), 32'h4);

    // Ack in the expiry cycle wins over the timeout
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("t4b_error_cleared", 32'(error), 0);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (14) @(negedge clk);
    chk("t4b_still_req", 32'(imem_req), 1);
    imem_ack = 1; imem_data = 16'h0000;
    @(negedge clk);
    imem_ack = 0;
    chk("t4b_ack_wins", 32'({error, imem_req}), 0);
    @(negedge clk);
    chk("t4b_nop_no_strobe", 32'({clk_en, wr_dest, movi_lo, movi_hi, sel_mem}), 0);
    @(negedge clk);
    retire_gap();
    chk("t4b_addr1", 32'(imem_addr), 32'h01);

    // 6: asynchronous reset in the middle of a MEM wait
    fetch(16'hD280);
    @(negedge clk);
    chk("t6_in_mem", 32'(dmem_req), 1);
    #1;
    rst_n = 0;
    #1;
    chk("t6_rst_reqs", 32'({dmem_req, dmem_we, imem_req}), 0);
    chk("t6_rst_outs", 32'({clk_en, wr_dest, sel_mem, alu_op, dest, imem_addr}), 0);
    @(negedge clk);
    rst_n = 1;

    // 5: RESET_PC=FF, NOP wraps PC to 00, then HALT
    start_w = 1;
    @(negedge clk);
    start_w = 0;
    chk("t5_addr_ff", 32'({imem_req_w, imem_addr_w}), 32'h1FF);
    imem_ack_w = 1; imem_data_w = 16'h0000;
    @(negedge clk);
    imem_ack_w = 0;
    @(negedge clk);
    chk("t5_nop_no_strobe", 32'({clk_en_w, wr_dest_w, movi_lo_w, movi_hi_w, sel_mem_w}), 0);
    @(negedge clk);
`ifdef DEC_SINGLE_STEP_EN
    chk("t5_step_hold", 32'(imem_req_w), 0);
    step_w = 1;
    @(negedge clk);
    step_w = 0;
`endif
    chk("t5_pc_wrap", 32'({imem_req_w, imem_addr_w}), 32'h100);
    imem_ack_w = 1; imem_data_w = 16'hF000;
    @(negedge clk);
    imem_ack_w = 0; imem_data_w = '0;
    @(negedge clk);
    chk("t5_halted", 32'(halted_w), 1);
    n_hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req_w || dmem_req_w) n_hi++;
      @(negedge clk);
    end
    chk("t5_no_req_after_halt", 32'(n_hi), 0);
    chk("t5_halt_state", 32'({halted_w, error_w, dmem_we_w, clk_en_w, wr_dest_w, sel_mem_w}), 32'h20);
    chk("t5_halt_fields", 32'({alu_op_w, dest_w, src1_w, src2_w, imm_w}), 32'({4'hF, 17'h0}));

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
